// File: rtl/periph_pkg.sv
// Shared register map, status/control bit positions and serializer state encoding
// for the peripheral I/O controller.
package periph_pkg;

  localparam int unsigned REG_SEL_W = 3;

  localparam logic [REG_SEL_W-1:0] REG_CYCLE_LO  = 3'd0;
  localparam logic [REG_SEL_W-1:0] REG_CYCLE_HI  = 3'd1;
  localparam logic [REG_SEL_W-1:0] REG_UART_TX   = 3'd2;
  localparam logic [REG_SEL_W-1:0] REG_UART_STAT = 3'd3;
  localparam logic [REG_SEL_W-1:0] REG_TMR_CMP   = 3'd4;
  localparam logic [REG_SEL_W-1:0] REG_TMR_CTRL  = 3'd5;

  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_BUSY  = 2;
  localparam int unsigned STAT_OVF   = 3;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_EXP = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/peripheral_io_controller_if.sv
// Single-cycle peripheral port: request strobe, direction, address, write and read data.
interface peripheral_io_controller_if;
  logic        req;
  logic        wren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output req, wren, addr, wdata, input rdata);
  modport slave  (input req, wren, addr, wdata, output rdata);
endinterface

// File: rtl/peripheral_io_controller_fifo.sv
// Synchronous FIFO; a push while full is accepted only if a pop happens at the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_c, do_pop_c;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_pop_c  = pop_i & ~empty_o;
  assign do_push_c = push_i & (~full_o | do_pop_c);

  always_comb begin
    count_d = count_q;
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/peripheral_io_controller.sv
// Peripheral slave: 64-bit cycle counter, compare timer with level IRQ,
// and FIFO-buffered 8N1 UART transmitter.
module peripheral_io_controller
  import periph_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clock_i,
  input  logic                              resetn_i,
  peripheral_io_controller_if.slave         bus_if,
  output logic                              uart_tx_o,
  output logic                              timer_irq_o
);

  localparam int unsigned BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [REG_SEL_W-1:0] reg_sel_c;
  logic                 wr_c, rd_lo_c, unused_addr_c;

  logic [63:0] cycle_q;
  logic [31:0] hi_snap_q;
  logic [31:0] cmp_q, cmp_d, tcount_q, tcount_d;
  logic        en_q, en_d, exp_q, exp_d, ovf_q, ovf_d, tmr_hit_c;

  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d, baud_end_c, busy_c;

  logic             fifo_push_c, fifo_pop_c, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      rdata_c;

  assign reg_sel_c     = bus_if.addr[4:2];
  assign wr_c          = bus_if.req & bus_if.wren;
  assign rd_lo_c       = bus_if.req & ~bus_if.wren & (reg_sel_c == REG_CYCLE_LO);
  assign fifo_push_c   = wr_c & (reg_sel_c == REG_UART_TX);
  assign unused_addr_c = ^{bus_if.addr[31:5], bus_if.addr[1:0]};

  assign tmr_hit_c  = en_q & (tcount_q == cmp_q);
  assign baud_end_c = (baud_q == BAUD_W'(CLK_DIV - 1));
  assign busy_c     = (state_q != ST_IDLE);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clock_i),
    .rst_ni  (resetn_i),
    .push_i  (fifo_push_c),
    .pop_i   (fifo_pop_c),
    .wdata_i (bus_if.wdata[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Timer and sticky flags; a hardware EXP/OVF set beats a same-edge clear.
  always_comb begin
    tcount_d = tcount_q;
    cmp_d    = cmp_q;
    en_d     = en_q;
    exp_d    = exp_q;
    ovf_d    = ovf_q;
    if (en_q) tcount_d = tmr_hit_c ? '0 : tcount_q + 32'd1;
    if (wr_c) begin
      case (reg_sel_c)
        REG_UART_STAT: if (bus_if.wdata[STAT_OVF]) ovf_d = 1'b0;
        REG_TMR_CMP: begin
          cmp_d    = bus_if.wdata;
          tcount_d = '0;
        end
        REG_TMR_CTRL: begin
          en_d = bus_if.wdata[CTRL_EN];
          if (bus_if.wdata[CTRL_EXP]) exp_d = 1'b0;
          if (bus_if.wdata[CTRL_EN] && !en_q) tcount_d = '0;
        end
        default: ;
      endcase
    end
    if (tmr_hit_c) exp_d = 1'b1;
    if (fifo_push_c && fifo_full && !fifo_pop_c) ovf_d = 1'b1;
  end

  // Serializer next state; tx is registered from the next-state view so it
  // changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    fifo_pop_c = 1'b0;
    tx_d       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          shreg_d    = fifo_rdata;
          baud_d     = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end_c) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end_c) begin
          baud_d    = '0;
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end_c) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          if (!fifo_empty) begin
            fifo_pop_c = 1'b1;
            shreg_d    = fifo_rdata;
            state_d    = ST_START;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cycle_q   <= '0;
      hi_snap_q <= '0;
      cmp_q     <= '0;
      tcount_q  <= '0;
      en_q      <= 1'b0;
      exp_q     <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      cycle_q   <= cycle_q + 64'd1;
      if (rd_lo_c) hi_snap_q <= cycle_q[63:32];
      cmp_q     <= cmp_d;
      tcount_q  <= tcount_d;
      en_q      <= en_d;
      exp_q     <= exp_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    rdata_c = '0;
    case (reg_sel_c)
      REG_CYCLE_LO:  rdata_c = cycle_q[31:0];
      REG_CYCLE_HI:  rdata_c = hi_snap_q;
      REG_UART_STAT: rdata_c = {20'b0, 8'(fifo_count), ovf_q, busy_c, fifo_empty, fifo_full};
      REG_TMR_CMP:   rdata_c = cmp_q;
      REG_TMR_CTRL:  rdata_c = {30'b0, exp_q, en_q};
      default:       rdata_c = '0;
    endcase
  end

  assign bus_if.rdata = resetn_i ? rdata_c : 32'd0;
  assign uart_tx_o    = tx_q;
  assign timer_irq_o  = exp_q;

endmodule

// File: tb/tb_peripheral_io_controller.sv
// Self-checking bench: UART bytes are queued when written and compared as the
// line monitor decodes frames; registers and timer checked against expected values.
module tb_peripheral_io_controller;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEPTH   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic tx, irq;
  always #5 clk = ~clk;

  peripheral_io_controller_if bus_if();

  peripheral_io_controller #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clock_i     (clk),
    .resetn_i    (rst_n),
    .bus_if      (bus_if),
    .uart_tx_o   (tx),
    .timer_irq_o (irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference cycle counter
  logic [63:0] cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 64'd1;
  end

  logic [7:0] sb[$];
  time        starts[$];
  int         rx_cnt = 0;

  // Line monitor: decodes 8N1 frames and scores them against the queue
  initial begin : monitor
    logic [7:0] b;
    logic       ok;
    time        st;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        ok = 1'b1;
        st = $time;
        b  = '0;
        @(negedge clk);
        if (!rst_n) ok = 1'b0;
        else check("start_bit", 64'(tx), 64'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          if (!rst_n) ok = 1'b0;
          b[i] = tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        if (!rst_n) ok = 1'b0;
        if (ok) begin
          check("stop_bit", 64'(tx), 64'd1);
          if (sb.size() == 0) begin
            check("uart_extra_frame", 64'(sb.size()), 64'd1);
          end else begin
            check("uart_byte", 64'(b), 64'(sb.pop_front()));
            rx_cnt++;
            starts.push_back(st);
          end
        end
      end
    end
  end

  // Bus tasks are entered at a falling edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.req = 1'b1; bus_if.wren = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    @(negedge clk);
    bus_if.req = 1'b0; bus_if.wren = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.req = 1'b1; bus_if.wren = 1'b0; bus_if.addr = a;
    #1 d = bus_if.rdata;
    @(negedge clk);
    bus_if.req = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus_if.req = 1'b0; bus_if.addr = a;
    #1 d = bus_if.rdata;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] d;
    logic [7:0]  v;
    int          lows, stat_bad, base;
    logic        exp_tx;

    bus_if.req = 1'b0; bus_if.wren = 1'b0; bus_if.addr = 32'hC; bus_if.wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_data_o", 64'(bus_if.rdata), 64'd0);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_irq", 64'(irq), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: cycle counter after 100 clocks, idle status throughout
    lows = 0; stat_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (bus_if.rdata !== 32'h2) stat_bad++;
    end
    check("t1_tx_idle", 64'(lows), 64'd0);
    check("t1_stat_idle", 64'(stat_bad), 64'd0);
    rd(32'h0, d);
    check("t1_cycle_lo", 64'(d), 64'd100);
    rd(32'h4, d);
    check("t1_cycle_hi", 64'(d), 64'd0);

    // 2: single frame bit timing
    v = 8'hA5;
    sb.push_back(v);
    wr(32'h8, 32'(v));
    for (int n = 0; n < 42; n++) begin
      peek(32'hC, d);
      if (n == 0)      exp_tx = 1'b1;
      else if (n <= 4) exp_tx = 1'b0;
      else if (n <= 36) exp_tx = v[(n - 5) / 4];
      else             exp_tx = 1'b1;
      check($sformatf("t2_tx_n%0d", n), 64'(tx), 64'(exp_tx));
      if (n == 40) check("t2_busy_stop", 64'(d[2]), 64'd1);
      if (n == 41) check("t2_busy_idle", 64'(d[2]), 64'd0);
      @(negedge clk);
    end
    check("t2_rx_count", 64'(rx_cnt), 64'd1);
    peek(32'hC, d);
    check("t2_stat", 64'(d), 64'h2);
    @(negedge clk);

    // 3: overflow with back-to-back writes, contiguous frames, OVF clear
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb.push_back(8'h11 + 8'(i));
      wr(32'h8, 32'(8'h11 + 8'(i)));
    end
    peek(32'hC, d);
    check("t3_stat_ovf", 64'(d), 64'h4D);
    @(negedge clk);
    wr(32'hC, 32'h8);
    peek(32'hC, d);
    check("t3_stat_ovf_clr", 64'(d), 64'h45);
    for (int i = 0; i < 800 && sb.size() != 0; i++) @(negedge clk);
    check("t3_drain", 64'(sb.size()), 64'd0);
    repeat (4) @(negedge clk);
    check("t3_frames", 64'(starts.size()), 64'd5);
    for (int i = 1; i < starts.size(); i++)
      check($sformatf("t3_gap%0d", i), 64'(starts[i] - starts[i-1]), 64'(CLK_DIV * 10 * 10));
    peek(32'hC, d);
    check("t3_stat_idle", 64'(d), 64'h2);
    @(negedge clk);

    // 4: compare timer period, W1C, same-edge set/clear
    wr(32'h10, 32'd9);
    rd(32'h10, d);
    check("t4_cmp", 64'(d), 64'd9);
    wr(32'h14, 32'h1);
    for (int m = 0; m < 32; m++) begin
      check($sformatf("t4_irq_m%0d", m), 64'(irq), 64'(m == 10 || m == 20 || m >= 30));
      if (m == 10 || m == 20 || m == 29) begin
        bus_if.req = 1'b1; bus_if.wren = 1'b1; bus_if.addr = 32'h14; bus_if.wdata = 32'h3;
      end else begin
        bus_if.req = 1'b0; bus_if.wren = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.req = 1'b0; bus_if.wren = 1'b0;
    rd(32'h14, d);
    check("t4_ctrl_set", 64'(d), 64'h3);
    wr(32'h14, 32'h2);
    rd(32'h14, d);
    check("t4_ctrl_off", 64'(d), 64'h0);
    repeat (20) @(negedge clk);
    check("t4_irq_off", 64'(irq), 64'd0);

    // 5: async reset in the middle of the second frame
    base = rx_cnt;
    sb.push_back(8'h3C); sb.push_back(8'h00); sb.push_back(8'hFF);
    wr(32'h8, 32'h3C); wr(32'h8, 32'h00); wr(32'h8, 32'hFF);
    for (int i = 0; i < 200 && rx_cnt == base; i++) @(negedge clk);
    check("t5_frame1", 64'(rx_cnt), 64'(base + 1));
    repeat (15) @(negedge clk);
    bus_if.addr = 32'hC;
    #2 check("t5_tx_mid_data", 64'(tx), 64'd0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t5_tx_async", 64'(tx), 64'd1);
    check("t5_data_o_rst", 64'(bus_if.rdata), 64'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    peek(32'hC, d);
    check("t5_stat", 64'(d), 64'h2);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("t5_no_frames", 64'(lows), 64'd0);
    check("t5_rx_count", 64'(rx_cnt), 64'(base + 1));

    // 6: reserved offsets and read-only writes
    rd(32'h18, d);
    check("t6_res6", 64'(d), 64'd0);
    wr(32'h1C, 32'hDEAD_BEEF);
    rd(32'h1C, d);
    check("t6_res7", 64'(d), 64'd0);
    wr(32'h0, 32'hFFFF);
    peek(32'h0, d);
    check("t6_cycle_lo", 64'(d), 64'(cyc[31:0]));
    @(negedge clk);
    rd(32'h0, d);
    rd(32'h4, d);
    check("t6_cycle_hi", 64'(d), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
